// File: rtl/red_pitaya_haze_slew.sv
// Output conditioner for the haze gain path: clamps the signed sample to a
// programmable [MIN, MAX] window, then slew-limits it on a prescaled tick.
module red_pitaya_haze_slew #(
  parameter int PRESCBITS = 16,
  parameter int CNTBITS   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic signed [13:0] dat_i,
  output logic signed [13:0] dat_o,
  output logic               slewing_o,
  input  logic [15:0]        addr,
  input  logic               wen,
  input  logic               ren,
  output logic               ack,
  output logic [31:0]        rdata,
  input  logic [31:0]        wdata
);

  localparam logic [15:0] ADDR_MIN    = 16'h0100;
  localparam logic [15:0] ADDR_MAX    = 16'h0104;
  localparam logic [15:0] ADDR_STEP   = 16'h0108;
  localparam logic [15:0] ADDR_PRESC  = 16'h010C;
  localparam logic [15:0] ADDR_CTRL   = 16'h0110;
  localparam logic [15:0] ADDR_SATCNT = 16'h0114;
  localparam logic [15:0] ADDR_PBITS  = 16'h0200;

  localparam logic [CNTBITS-1:0]   SAT_FULL  = {CNTBITS{1'b1}};
  localparam logic [CNTBITS-1:0]   SAT_ONE   = {{(CNTBITS-1){1'b0}}, 1'b1};
  localparam logic [PRESCBITS-1:0] PRESC_ONE = {{(PRESCBITS-1){1'b0}}, 1'b1};

  logic signed [13:0]   r_min;
  logic signed [13:0]   r_max;
  logic [13:0]          r_step;
  logic [PRESCBITS-1:0] r_presc;
  logic [1:0]           r_ctrl;
  logic [CNTBITS-1:0]   r_satcnt;
  logic signed [13:0]   r_tgt;
  logic                 r_sat_evt;
  logic [PRESCBITS-1:0] r_cnt;
  logic signed [13:0]   r_y;

  logic                 w_wr_min;
  logic                 w_wr_max;
  logic                 w_wr_step;
  logic                 w_wr_presc;
  logic                 w_wr_ctrl;
  logic                 w_wr_sat;
  logic                 w_above;
  logic                 w_below;
  logic                 w_slew_en;
  logic                 w_hold;
  logic                 w_tick;
  logic signed [15:0]   w_y_ext;
  logic signed [15:0]   w_diff;
  logic signed [15:0]   w_step_s;
  logic signed [15:0]   w_y_up;
  logic signed [15:0]   w_y_dn;
  logic signed [13:0]   w_y_next;
  logic [31:0]          w_rd_data;
  logic                 w_unused;

  assign w_wr_min   = wen && (addr == ADDR_MIN);
  assign w_wr_max   = wen && (addr == ADDR_MAX);
  assign w_wr_step  = wen && (addr == ADDR_STEP);
  assign w_wr_presc = wen && (addr == ADDR_PRESC);
  assign w_wr_ctrl  = wen && (addr == ADDR_CTRL);
  assign w_wr_sat   = wen && (addr == ADDR_SATCNT);
  assign w_unused   = ^wdata[31:14];

  assign w_above   = (dat_i > r_max);
  assign w_below   = (dat_i < r_min);
  assign w_slew_en = r_ctrl[0];
  assign w_hold    = r_ctrl[1];
  assign w_tick    = (r_cnt == r_presc);

  // Differences are taken at 16 bits so the unsigned STEP compares as a positive value.
  assign w_y_ext  = {{2{r_y[13]}}, r_y};
  assign w_diff   = {{2{r_tgt[13]}}, r_tgt} - w_y_ext;
  assign w_step_s = {2'b00, r_step};
  assign w_y_up   = w_y_ext + w_step_s;
  assign w_y_dn   = w_y_ext - w_step_s;

  assign dat_o     = r_y;
  assign slewing_o = (r_y != r_tgt);

  // Configuration registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_min   <= 14'h2000;
      r_max   <= 14'h1FFF;
      r_step  <= 14'h1FFF;
      r_presc <= {PRESCBITS{1'b0}};
      r_ctrl  <= 2'b00;
    end else begin
      if (w_wr_min)   r_min   <= wdata[13:0];
      if (w_wr_max)   r_max   <= wdata[13:0];
      if (w_wr_step)  r_step  <= wdata[13:0];
      if (w_wr_presc) r_presc <= wdata[PRESCBITS-1:0];
      if (w_wr_ctrl)  r_ctrl  <= wdata[1:0];
    end
  end

  // Clamp stage; MAX wins when the window is inverted. Clear beats increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tgt     <= 14'sd0;
      r_sat_evt <= 1'b0;
      r_satcnt  <= {CNTBITS{1'b0}};
    end else begin
      r_tgt     <= w_above ? r_max : (w_below ? r_min : dat_i);
      r_sat_evt <= w_above | w_below;
      if (w_wr_sat) begin
        r_satcnt <= {CNTBITS{1'b0}};
      end else if (r_sat_evt && (r_satcnt != SAT_FULL)) begin
        r_satcnt <= r_satcnt + SAT_ONE;
      end
    end
  end

  always_comb begin
    w_y_next = r_y;
    if (w_hold) begin
      w_y_next = r_y;
    end else if (!w_slew_en) begin
      w_y_next = r_tgt;
    end else if (!w_tick) begin
      w_y_next = r_y;
    end else if (w_diff > w_step_s) begin
      w_y_next = w_y_up[13:0];
    end else if (w_diff < -w_step_s) begin
      w_y_next = w_y_dn[13:0];
    end else begin
      w_y_next = r_tgt;
    end
  end

  // Slew prescaler and output register; HOLD freezes both so the tick phase survives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= {PRESCBITS{1'b0}};
      r_y   <= 14'sd0;
    end else begin
      if (w_wr_presc) begin
        r_cnt <= {PRESCBITS{1'b0}};
      end else if (w_hold) begin
        r_cnt <= r_cnt;
      end else if (w_tick) begin
        r_cnt <= {PRESCBITS{1'b0}};
      end else begin
        r_cnt <= r_cnt + PRESC_ONE;
      end
      r_y <= w_y_next;
    end
  end

  always_comb begin
    w_rd_data = 32'h0000_0000;
    case (addr)
      ADDR_MIN:    w_rd_data = {{18{r_min[13]}}, r_min};
      ADDR_MAX:    w_rd_data = {{18{r_max[13]}}, r_max};
      ADDR_STEP:   w_rd_data = {18'd0, r_step};
      ADDR_PRESC:  w_rd_data = 32'(r_presc);
      ADDR_CTRL:   w_rd_data = {30'd0, r_ctrl};
      ADDR_SATCNT: w_rd_data = 32'(r_satcnt);
      ADDR_PBITS:  w_rd_data = 32'(PRESCBITS);
      default:     w_rd_data = 32'h0000_0000;
    endcase
  end

  // Register bus response, valid one cycle after the strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack   <= 1'b0;
      rdata <= 32'h0000_0000;
    end else begin
      ack   <= wen | ren;
      rdata <= w_rd_data;
    end
  end

endmodule

// File: tb/tb_red_pitaya_haze_slew.sv
// Directed bench for red_pitaya_haze_slew with a cycle-level reference model.
module tb_red_pitaya_haze_slew;

  logic               clk;
  logic               rst_i;
  logic signed [13:0] dat_i;
  logic signed [13:0] dat_o;
  logic               slewing_o;
  logic [15:0]        addr;
  logic               wen;
  logic               ren;
  logic               ack;
  logic [31:0]        rdata;
  logic [31:0]        wdata;

  red_pitaya_haze_slew #(.PRESCBITS(16), .CNTBITS(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .dat_i(dat_i), .dat_o(dat_o),
    .slewing_o(slewing_o), .addr(addr), .wen(wen), .ren(ren),
    .ack(ack), .rdata(rdata), .wdata(wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  int cyc_n = 0;

  // Reference model state, plain integers.
  bit          m_valid = 0;
  int          m_min, m_max, m_step, m_presc, m_sat, m_tgt, m_phase, m_y;
  bit          m_slew, m_hold, m_evt, m_ack;
  logic [31:0] m_rdata;

  int rec_val [8];
  int rec_cyc [8];
  bit rec_slew [8];
  int nrec;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s at cycle %0d: got %0d (0x%0h) expected %0d (0x%0h)", nm, cyc_n, act, act, exp, exp);
    end
  endtask

  function automatic int s14(input logic [13:0] v);
    return v[13] ? int'(v) - 16384 : int'(v);
  endfunction

  function automatic logic [31:0] mread(input logic [15:0] a);
    case (a)
      16'h0100: return 32'(m_min);
      16'h0104: return 32'(m_max);
      16'h0108: return 32'(m_step);
      16'h010C: return 32'(m_presc);
      16'h0110: return {30'd0, m_hold, m_slew};
      16'h0114: return 32'(m_sat);
      16'h0200: return 32'd16;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_update(input logic r, input int d, input logic [15:0] a,
                              input logic w, input logic rn, input logic [31:0] wd);
    int n_y, n_phase, n_sat;
    bit tick;
    if (r) begin
      m_valid = 1; m_min = -8192; m_max = 8191; m_step = 8191; m_presc = 0;
      m_slew = 0; m_hold = 0; m_sat = 0; m_tgt = 0; m_evt = 0; m_phase = 0;
      m_y = 0; m_ack = 0; m_rdata = 32'd0;
      return;
    end
    tick = (m_phase == m_presc);
    // Move the output toward the target by no more than one step per tick.
    n_y = m_y;
    if (!m_hold) begin
      if (!m_slew) n_y = m_tgt;
      else if (tick) begin
        if (m_tgt - m_y > m_step)      n_y = m_y + m_step;
        else if (m_y - m_tgt > m_step) n_y = m_y - m_step;
        else                           n_y = m_tgt;
      end
    end
    if (w && a == 16'h010C) n_phase = 0;
    else if (m_hold)        n_phase = m_phase;
    else if (tick)          n_phase = 0;
    else                    n_phase = m_phase + 1;
    if (w && a == 16'h0114)          n_sat = 0;
    else if (m_evt && m_sat < 65535) n_sat = m_sat + 1;
    else                             n_sat = m_sat;
    m_ack   = w | rn;
    m_rdata = mread(a);
    m_evt   = (d > m_max) || (d < m_min);
    m_tgt   = (d > m_max) ? m_max : ((d < m_min) ? m_min : d);
    m_y = n_y; m_phase = n_phase; m_sat = n_sat;
    if (w) begin
      case (a)
        16'h0100: m_min = s14(wd[13:0]);
        16'h0104: m_max = s14(wd[13:0]);
        16'h0108: m_step = int'(wd[13:0]);
        16'h010C: m_presc = int'(wd[15:0]);
        16'h0110: begin m_slew = wd[0]; m_hold = wd[1]; end
        default: ;
      endcase
    end
  endtask

  // One clock: model advances on the edge, every DUT output is compared 1 time unit later.
  task automatic cyc();
    logic r, w, rn;
    int d;
    logic [15:0] a;
    logic [31:0] wd;
    r = rst_i; d = int'(dat_i); a = addr; w = wen; rn = ren; wd = wdata;
    @(posedge clk);
    model_update(r, d, a, w, rn, wd);
    cyc_n++;
    #1;
    if (m_valid) begin
      chk("dat_o", dat_o, m_y);
      chk("slewing_o", slewing_o, (m_y != m_tgt));
      chk("ack", ack, m_ack);
      chk("rdata", rdata, m_rdata);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    cyc();
    wen = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] v);
    addr = a; ren = 1'b1;
    cyc();
    v = rdata;
    chk("ack_after_ren", ack, 1'b1);
    ren = 1'b0;
  endtask

  task automatic watch(input int nchg, input int maxcyc);
    int prev;
    prev = int'(dat_o);
    nrec = 0;
    for (int i = 0; i < maxcyc && nrec < nchg; i++) begin
      cyc();
      if (int'(dat_o) != prev) begin
        rec_val[nrec] = int'(dat_o); rec_cyc[nrec] = cyc_n; rec_slew[nrec] = slewing_o;
        nrec++;
        prev = int'(dat_o);
      end
    end
    chk("watch_change_count", nrec, nchg);
  endtask

  initial begin
    logic [31:0] v;
    int sc [4];
    int up_exp [5];
    int dn_exp [5];
    int t200;
    up_exp = '{100, 200, 300, 400, 450};
    dn_exp = '{350, 250, 150, 50, -50};

    rst_i = 1'b1; dat_i = 14'sd0; addr = 16'h0000; wen = 1'b0; ren = 1'b0; wdata = 32'd0;
    idle(2);
    rst_i = 1'b0;
    chk("reset_dat_o", dat_o, 14'sd0);
    chk("reset_ack", ack, 1'b0);

    rd(16'h0100, v); chk("rd_min", v, 32'hFFFFE000);
    rd(16'h0104, v); chk("rd_max", v, 32'h00001FFF);
    rd(16'h0108, v); chk("rd_step", v, 32'h00001FFF);
    rd(16'h010C, v); chk("rd_presc", v, 32'd0);
    rd(16'h0110, v); chk("rd_ctrl", v, 32'd0);
    rd(16'h0114, v); chk("rd_satcnt", v, 32'd0);
    rd(16'h0200, v); chk("rd_prescbits", v, 32'd16);
    rd(16'h0300, v); chk("rd_unmapped", v, 32'd0);
    cyc(); chk("ack_drops", ack, 1'b0);

    // Bypass latency.
    dat_i = 14'sd1000;
    cyc(); chk("bypass_lat1", dat_o, 14'sd0);
    cyc(); chk("bypass_lat2", dat_o, 14'sd1000);

    // Clamp to MIN = -100 and count events.
    wr(16'h0100, 32'hFFFFFF9C);
    dat_i = 14'h2000;
    idle(2); chk("clamp_min", dat_o, -14'sd100);
    addr = 16'h0114; ren = 1'b1;
    for (int i = 0; i < 4; i++) begin cyc(); sc[i] = int'(rdata); end
    ren = 1'b0;
    for (int i = 1; i < 4; i++) chk("satcnt_rate", sc[i] - sc[i-1], 1);

    idle(70000);
    rd(16'h0114, v); chk("satcnt_saturated", v, 32'h0000FFFF);
    wr(16'h0114, 32'd0);
    rd(16'h0114, v); chk("satcnt_clear_wins", v, 32'd0);
    wr(16'h0100, 32'hFFFFE000);
    dat_i = 14'sd0;
    idle(3);

    // Slew ramp up and down.
    wr(16'h0108, 32'd100);
    wr(16'h010C, 32'd3);
    wr(16'h0110, 32'd1);
    dat_i = 14'sd450;
    watch(5, 60);
    for (int i = 0; i < 5; i++) chk("ramp_up_val", rec_val[i], up_exp[i]);
    for (int i = 1; i < 5; i++) chk("ramp_up_gap", rec_cyc[i] - rec_cyc[i-1], 4);
    chk("slewing_mid", rec_slew[3], 1'b1);
    chk("slewing_done", rec_slew[4], 1'b0);

    dat_i = -14'sd50;
    watch(5, 60);
    for (int i = 0; i < 5; i++) chk("ramp_dn_val", rec_val[i], dn_exp[i]);
    for (int i = 1; i < 5; i++) chk("ramp_dn_gap", rec_cyc[i] - rec_cyc[i-1], 4);

    // HOLD for 10 cycles at 200.
    dat_i = 14'sd0;
    watch(1, 20); chk("ramp_to_zero", rec_val[0], 0);
    dat_i = 14'sd450;
    watch(2, 40); chk("hold_pre_val", rec_val[1], 200);
    t200 = rec_cyc[1];
    wr(16'h0110, 32'd3);
    for (int i = 0; i < 9; i++) begin cyc(); chk("hold_frozen", dat_o, 14'sd200); end
    wr(16'h0110, 32'd1);
    chk("hold_frozen", dat_o, 14'sd200);
    watch(1, 40);
    chk("hold_resume_val", rec_val[0], 300);
    chk("hold_resume_gap", rec_cyc[0] - t200, 14);

    // Reset in the middle of the ramp.
    rst_i = 1'b1; dat_i = 14'sd0;
    cyc();
    rst_i = 1'b0;
    chk("midramp_reset_dat", dat_o, 14'sd0);
    chk("midramp_reset_slew", slewing_o, 1'b0);
    rd(16'h0110, v); chk("rst_ctrl", v, 32'd0);
    rd(16'h0108, v); chk("rst_step", v, 32'h00001FFF);
    rd(16'h010C, v); chk("rst_presc", v, 32'd0);
    rd(16'h0100, v); chk("rst_min", v, 32'hFFFFE000);
    rd(16'h0114, v); chk("rst_satcnt", v, 32'd0);

    // Inverted window.
    wr(16'h0100, 32'd500);
    wr(16'h0104, 32'd100);
    dat_i = 14'sd1000;
    idle(2); chk("inverted_high", dat_o, 14'sd100);
    dat_i = 14'sd0;
    idle(2); chk("inverted_low", dat_o, 14'sd500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
